// File: rtl/uart_pkg.sv
`default_nettype none
// =====================================================================
// uart_pkg: shared UART constants, tx state type and counter-width helper.
// Revision: 1.0
// =====================================================================
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  // An oversample of 1 still needs a 1-bit counter so the vector is never zero-width.
  function automatic int tick_cnt_w(input int oversample);
    return (oversample > 1) ? $clog2(oversample) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// =====================================================================
// uart_bit_timer: counts b_tick to OVERSAMPLE, pulses bit_end_o on the last.
// Revision: 1.0
// =====================================================================
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic b_tick_i,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_end_o
);

  localparam int            CW   = tick_cnt_w(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_w;

  assign last_w    = (cnt_q == LAST);
  assign bit_end_o = en_i & b_tick_i & last_w;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && b_tick_i) begin
      cnt_d = last_w ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// =====================================================================
// uart_tx_cfg: parametrised UART transmitter (data bits, parity, stops).
// Optional UART_TX_BREAK_EN adds a brk input that holds the line low.
// Revision: 1.0
// =====================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 b_tick,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 1 || OVERSAMPLE > 16) begin : g_param_check
    $fatal(1, "uart_tx_cfg: illegal parameter combination");
  end

  localparam int             BCW       = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 brk_w, par_w, bit_end_w;

`ifdef UART_TX_BREAK_EN
  assign brk_w = brk;
`else
  assign brk_w = 1'b0;
`endif

  assign par_w = (PARITY_MODE == PAR_ODD) ? ~^tx_data : ^tx_data;

  // Timer is held clear in WAIT so the start bit gets a full OVERSAMPLE ticks.
  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .b_tick_i  (b_tick),
    .clr_i     (state_q == ST_WAIT),
    .en_i      ((state_q != ST_IDLE) && (state_q != ST_WAIT)),
    .bit_end_o (bit_end_w)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d   = ~brk_w;
        busy_d = brk_w;
        if (start && !brk_w) begin
          state_d = ST_WAIT;
          shreg_d = tx_data;
          par_d   = par_w;
          busy_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (b_tick) begin
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_w) begin
          state_d   = ST_DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end_w) begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            if (PARITY_MODE != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_w) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end_w) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// =====================================================================
// tb_uart_tx_cfg: directed bench for uart_tx_cfg in 8N1, 8E1, 8O1, 7N2 builds.
// Revision: 1.0
// =====================================================================
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       b_tick;
  int         tick_div;
  int         tick_c;
  logic [3:0] start_v;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  wire  [3:0] tx_v, busy_v, done_v;
  logic [1:0] sel;
  wire        cur_tx   = tx_v[sel];
  wire        cur_busy = busy_v[sel];
  wire        cur_done = done_v[sel];
  int         total, bad;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_d0 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .start(start_v[0]), .tx_data(d0),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));

  uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_d1 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .start(start_v[1]), .tx_data(d1),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));

  uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_d2 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .start(start_v[2]), .tx_data(d2),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));

  uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(4)) u_d3 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .start(start_v[3]), .tx_data(d3),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx_busy(busy_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

  // b_tick: one clk high every tick_div clks (tick_div=1 holds it high).
  initial begin
    tick_c = 0;
    b_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_c++;
      if (tick_c >= tick_div) tick_c = 0;
      b_tick = (tick_c == 0);
    end
  end

  task automatic send(input int s, input logic [8:0] d);
    @(negedge clk);
    case (s)
      0: d0 = d[7:0];
      1: d1 = d[7:0];
      2: d2 = d[7:0];
      default: d3 = d[6:0];
    endcase
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
  endtask

  // Records the post-edge line value of every b_tick from the start edge up to
  // the tx_done cycle, then slices it into bit periods of os ticks.
  task automatic capture(input int os, output logic [15:0] bits, output int nticks,
                         output int wait_clks, output bit timing_ok, output bit busy_ok,
                         output bit timed_out);
    logic vals [0:511];
    bit   tk, started, fin;
    int   clks;
    bits = '0; nticks = 0; wait_clks = 0; timing_ok = 1'b1; busy_ok = 1'b1;
    timed_out = 1'b0; started = 1'b0; fin = 1'b0; clks = 0;
    while (!fin && !timed_out) begin
      @(posedge clk);
      tk = b_tick;
      #1;
      clks++;
      if (!started) begin
        wait_clks++;
        if (tk && cur_tx === 1'b0) started = 1'b1;
        else if (cur_busy !== 1'b1) busy_ok = 1'b0;
      end
      if (started) begin
        if (cur_done === 1'b1) begin
          fin = 1'b1;
          if (cur_busy !== 1'b0 || !tk || cur_tx !== 1'b1) busy_ok = 1'b0;
        end else begin
          if (cur_busy !== 1'b1) busy_ok = 1'b0;
          if (tk) begin
            if (nticks < 512) vals[nticks] = cur_tx;
            nticks++;
          end else if (nticks > 0 && nticks <= 512 && cur_tx !== vals[nticks-1]) begin
            timing_ok = 1'b0;
          end
        end
      end
      if (clks > 6000) timed_out = 1'b1;
    end
    if (nticks % os != 0 || nticks > 512) begin
      timing_ok = 1'b0;
    end else begin
      for (int b = 0; b < nticks / os && b < 16; b++) begin
        bits[b] = vals[b*os];
        for (int t = 1; t < os; t++)
          if (vals[b*os+t] !== vals[b*os]) timing_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (tx_v !== 4'hF) begin bad++; $display("FAIL reset_tx: got %b want 1111", tx_v); end
    total++; if (busy_v !== 4'h0) begin bad++; $display("FAIL reset_busy: got %b want 0000", busy_v); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (done_v !== 4'h0 || tx_v !== 4'hF) begin
      bad++; $display("FAIL reset_idle: got done=%b tx=%b want done=0000 tx=1111", done_v, tx_v);
    end
  endtask

  task automatic test_8n1();
    logic [15:0] bits; int nt, wc; bit tok, bok, to;
    logic [9:0] exp;
    sel = 2'd0;
    exp = {1'b1, 8'h55, 1'b0};
    send(0, 9'h055);
    capture(16, bits, nt, wc, tok, bok, to);
    total++; if (to) begin bad++; $display("FAIL 8n1_timeout: got timeout want frame end"); end
    total++; if (bits[9:0] !== exp) begin bad++; $display("FAIL 8n1_bits: got %b want %b", bits[9:0], exp); end
    total++; if (nt !== 160) begin bad++; $display("FAIL 8n1_ticks: got %0d want 160", nt); end
    total++; if (!tok) begin bad++; $display("FAIL 8n1_bit_timing: got uneven bit periods want 16 ticks each"); end
    total++; if (!bok) begin bad++; $display("FAIL 8n1_busy: got busy dropout want busy high until done"); end
    @(posedge clk); #1;
    total++; if (cur_done !== 1'b0 || cur_tx !== 1'b1) begin
      bad++; $display("FAIL 8n1_done_pulse: got done=%b tx=%b want done=0 tx=1", cur_done, cur_tx);
    end
  endtask

  task automatic test_parity();
    logic [15:0] bits; int nt, wc; bit tok, bok, to;
    logic [10:0] exp;
    sel = 2'd1;
    exp = {1'b1, 1'b1, 8'h07, 1'b0};
    send(1, 9'h007);
    capture(16, bits, nt, wc, tok, bok, to);
    total++; if (bits[10:0] !== exp || to) begin bad++; $display("FAIL even_bits: got %b want %b", bits[10:0], exp); end
    total++; if (nt !== 176 || !tok) begin bad++; $display("FAIL even_ticks: got %0d want 176", nt); end
    sel = 2'd2;
    exp = {1'b1, 1'b0, 8'h07, 1'b0};
    send(2, 9'h007);
    capture(16, bits, nt, wc, tok, bok, to);
    total++; if (bits[10:0] !== exp || to) begin bad++; $display("FAIL odd_bits: got %b want %b", bits[10:0], exp); end
    total++; if (nt !== 176 || !tok || !bok) begin bad++; $display("FAIL odd_ticks: got %0d want 176", nt); end
  endtask

  task automatic test_7n2();
    logic [15:0] bits; int nt, wc; bit tok, bok, to;
    logic [9:0] exp;
    sel = 2'd3;
    exp = {2'b11, 7'h7F, 1'b0};
    send(3, 9'h07F);
    fork
      capture(4, bits, nt, wc, tok, bok, to);
      begin
        repeat (30) @(negedge clk);
        d3 = 7'h00;
      end
    join
    total++; if (bits[9:0] !== exp || to) begin bad++; $display("FAIL 7n2_bits: got %b want %b", bits[9:0], exp); end
    total++; if (nt !== 40) begin bad++; $display("FAIL 7n2_ticks: got %0d want 40", nt); end
    total++; if (!tok || !bok) begin bad++; $display("FAIL 7n2_timing: got timing=%0d busy=%0d want 1 1", tok, bok); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; int nt, wc; bit tok, bok, to;
    logic [9:0] exp;
    int viol;
    sel = 2'd0;
    tick_div = 1;
    exp = {1'b1, 8'hA3, 1'b0};
    repeat (3) @(negedge clk);
    d0 = 8'hA3;
    start_v[0] = 1'b1;
    capture(16, bits, nt, wc, tok, bok, to);
    total++; if (bits[9:0] !== exp || nt !== 160 || to) begin
      bad++; $display("FAIL b2b_first: got bits=%b ticks=%0d want %b 160", bits[9:0], nt, exp);
    end
    fork
      capture(16, bits, nt, wc, tok, bok, to);
      begin
        repeat (60) @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
      end
    join
    total++; if (bits[9:0] !== exp || nt !== 160 || to) begin
      bad++; $display("FAIL b2b_second: got bits=%b ticks=%0d want %b 160", bits[9:0], nt, exp);
    end
    total++; if (wc !== 2) begin bad++; $display("FAIL b2b_gap: got %0d clks want 2", wc); end
    total++; if (!tok || !bok) begin bad++; $display("FAIL b2b_timing: got timing=%0d busy=%0d want 1 1", tok, bok); end
    viol = 0;
    repeat (40) begin
      @(negedge clk);
      if (cur_tx !== 1'b1 || cur_busy !== 1'b0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL b2b_no_third: got %0d busy cycles want 0", viol); end
    tick_div = 3;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] bits; int nt, wc; bit tok, bok, to;
    logic [9:0] exp;
    int dones;
    sel = 2'd0;
    send(0, 9'h0F0);
    repeat (3 * (16 * 4 + 8)) @(negedge clk);
    total++; if (cur_tx !== 1'b0 || cur_busy !== 1'b1) begin
      bad++; $display("FAIL rst_pre: got tx=%b busy=%b want tx=0 busy=1", cur_tx, cur_busy);
    end
    reset = 1'b0;
    #1;
    total++; if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0) begin
      bad++; $display("FAIL rst_async: got tx=%b busy=%b done=%b want 1 0 0", cur_tx, cur_busy, cur_done);
    end
    dones = 0;
    repeat (4) begin @(negedge clk); if (cur_done !== 1'b0) dones++; end
    reset = 1'b1;
    repeat (20) begin @(negedge clk); if (cur_done !== 1'b0 || cur_tx !== 1'b1) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL rst_no_done: got %0d bad cycles want 0", dones); end
    exp = {1'b1, 8'h12, 1'b0};
    send(0, 9'h012);
    capture(16, bits, nt, wc, tok, bok, to);
    total++; if (bits[9:0] !== exp || nt !== 160 || to || !tok) begin
      bad++; $display("FAIL rst_after: got bits=%b ticks=%0d want %b 160", bits[9:0], nt, exp);
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    logic [15:0] bits; int nt, wc; bit tok, bok, to;
    logic [9:0] exp;
    int viol;
    sel = 2'd0;
    @(negedge clk);
    brk = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cur_tx !== 1'b0 || cur_busy !== 1'b1) begin
      bad++; $display("FAIL brk_on: got tx=%b busy=%b want 0 1", cur_tx, cur_busy);
    end
    d0 = 8'h99;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    viol = 0;
    repeat (150) begin @(negedge clk); if (cur_tx !== 1'b0 || cur_done !== 1'b0) viol++; end
    total++; if (viol !== 0) begin bad++; $display("FAIL brk_hold: got %0d bad cycles want 0", viol); end
    brk = 1'b0;
    repeat (2) @(negedge clk);
    viol = 0;
    repeat (30) begin @(negedge clk); if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0) viol++; end
    total++; if (viol !== 0) begin bad++; $display("FAIL brk_release: got %0d bad cycles want 0", viol); end
    exp = {1'b1, 8'h41, 1'b0};
    send(0, 9'h041);
    capture(16, bits, nt, wc, tok, bok, to);
    total++; if (bits[9:0] !== exp || nt !== 160 || to) begin
      bad++; $display("FAIL brk_after: got bits=%b ticks=%0d want %b 160", bits[9:0], nt, exp);
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    tick_div = 3;
    sel = 2'd0;
    start_v = 4'h0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
